// File: rtl/tb_sim_sequencer_if.sv
// Sequencer <-> testbench-harness signal bundle. Signal names keep the sequencer's
// own _i/_o direction suffixes so both sides read the same way.
interface tb_sim_sequencer_if #(
    parameter int CNT_W = 32
);
    logic             start_i;
    logic [1:0]       boot_mode_i;
    logic             load_done_i;
    logic [CNT_W-1:0] max_cycles_i;
    logic             exit_valid_i;
    logic [31:0]      exit_value_i;
    logic [1:0]       vcd_mode_i;
    logic             vcd_trig_i;
    logic             dut_rst_no;
    logic             load_req_o;
    logic             vcd_on_o;
    logic [7:0]       vcd_seg_o;
    logic             heartbeat_o;
    logic [CNT_W-1:0] cycle_cnt_o;
    logic             done_o;
    logic             pass_o;
    logic             fail_o;
    logic             timeout_o;
    logic [31:0]      exit_value_o;

    modport slave (
        input  start_i, boot_mode_i, load_done_i, max_cycles_i, exit_valid_i,
               exit_value_i, vcd_mode_i, vcd_trig_i,
        output dut_rst_no, load_req_o, vcd_on_o, vcd_seg_o, heartbeat_o,
               cycle_cnt_o, done_o, pass_o, fail_o, timeout_o, exit_value_o
    );

    modport master (
        output start_i, boot_mode_i, load_done_i, max_cycles_i, exit_valid_i,
               exit_value_i, vcd_mode_i, vcd_trig_i,
        input  dut_rst_no, load_req_o, vcd_on_o, vcd_seg_o, heartbeat_o,
               cycle_cnt_o, done_o, pass_o, fail_o, timeout_o, exit_value_o
    );
endinterface

// File: rtl/tb_sim_sequencer.sv
// Simulation-control sequencer: DUT reset hold/release, boot handshake, run watchdog
// with heartbeat, exit/timeout capture and VCD gating with segment numbering.
module tb_sim_sequencer #(
    parameter int RST_HOLD_CYCLES  = 50,
    parameter int BOOT_DLY_CYCLES  = 100,
    parameter int HEARTBEAT_CYCLES = 100000,
    parameter int CNT_W            = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    tb_sim_sequencer_if.slave    bus
);
    localparam int DLY_W = 32;
    localparam logic [DLY_W-1:0] RST_LD  = DLY_W'(RST_HOLD_CYCLES - 1);
    localparam logic [DLY_W-1:0] BOOT_LD = DLY_W'(BOOT_DLY_CYCLES - 1);
    localparam logic [DLY_W-1:0] HB_LD   = DLY_W'(HEARTBEAT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RST_HOLD, S_BOOT_DLY, S_LOAD, S_RUN, S_DONE
    } state_t;

    state_t           r_state;
    logic [DLY_W-1:0] r_dly_cnt;
    logic [DLY_W-1:0] r_hb_cnt;
    logic [CNT_W-1:0] r_max;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic             r_dut_rst_n;
    logic             r_load_req;
    logic             r_vcd_on;
    logic [7:0]       r_vcd_seg;
    logic             r_heartbeat;
    logic             r_done;
    logic             r_pass;
    logic             r_fail;
    logic             r_timeout;
    logic [31:0]      r_exit_value;

    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_timeout_hit;
    logic             w_finish;
    logic             w_enter_run;
    logic             w_vcd_nxt;

    always_comb begin
        w_cnt_inc     = (r_cycle_cnt == '1) ? r_cycle_cnt : r_cycle_cnt + CNT_W'(1);
        w_timeout_hit = (r_max != '0) && (r_cycle_cnt == r_max - CNT_W'(1));
        w_finish      = (r_state == S_RUN) && (bus.exit_valid_i || w_timeout_hit);
        w_enter_run   = ((r_state == S_BOOT_DLY) && (r_dly_cnt == '0) && (bus.boot_mode_i != 2'd2)) ||
                        ((r_state == S_LOAD) && bus.load_done_i);
        w_vcd_nxt     = 1'b0;
        // Dumping only opens on RUN entry or during RUN; the exit edge always closes it.
        if ((r_state == S_RUN) && !w_finish) begin
            case (bus.vcd_mode_i)
                2'd1:    w_vcd_nxt = 1'b1;
                2'd2:    w_vcd_nxt = bus.vcd_trig_i;
                default: w_vcd_nxt = 1'b0;
            endcase
        end else if (w_enter_run) begin
            w_vcd_nxt = (bus.vcd_mode_i == 2'd1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_dly_cnt    <= '0;
            r_hb_cnt     <= '0;
            r_max        <= '0;
            r_cycle_cnt  <= '0;
            r_dut_rst_n  <= 1'b0;
            r_load_req   <= 1'b0;
            r_vcd_on     <= 1'b0;
            r_vcd_seg    <= '0;
            r_heartbeat  <= 1'b0;
            r_done       <= 1'b0;
            r_pass       <= 1'b0;
            r_fail       <= 1'b0;
            r_timeout    <= 1'b0;
            r_exit_value <= '0;
        end else begin
            r_heartbeat <= 1'b0;
            r_vcd_on    <= w_vcd_nxt;
            if (w_vcd_nxt && !r_vcd_on && (r_vcd_seg != 8'hFF))
                r_vcd_seg <= r_vcd_seg + 8'd1;

            case (r_state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        r_state   <= S_RST_HOLD;
                        r_dly_cnt <= RST_LD;
                        r_max     <= bus.max_cycles_i;
                    end
                end
                S_RST_HOLD: begin
                    if (r_dly_cnt == '0) begin
                        r_state     <= S_BOOT_DLY;
                        r_dut_rst_n <= 1'b1;
                        r_dly_cnt   <= BOOT_LD;
                    end else begin
                        r_dly_cnt <= r_dly_cnt - DLY_W'(1);
                    end
                end
                S_BOOT_DLY: begin
                    if (r_dly_cnt == '0) begin
                        if (bus.boot_mode_i == 2'd2) begin
                            r_state    <= S_LOAD;
                            r_load_req <= 1'b1;
                        end else begin
                            r_state  <= S_RUN;
                            r_hb_cnt <= HB_LD;
                        end
                    end else begin
                        r_dly_cnt <= r_dly_cnt - DLY_W'(1);
                    end
                end
                S_LOAD: begin
                    if (bus.load_done_i) begin
                        r_state    <= S_RUN;
                        r_load_req <= 1'b0;
                        r_hb_cnt   <= HB_LD;
                    end
                end
                S_RUN: begin
                    r_cycle_cnt <= w_cnt_inc;
                    if (bus.exit_valid_i) begin
                        r_state      <= S_DONE;
                        r_done       <= 1'b1;
                        r_exit_value <= bus.exit_value_i;
                        r_pass       <= (bus.exit_value_i == 32'd0);
                        r_fail       <= (bus.exit_value_i != 32'd0);
                    end else if (w_timeout_hit) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                        r_fail    <= 1'b1;
                    end else if (r_hb_cnt == '0) begin
                        // Modulo down-counter: reload and pulse on each HEARTBEAT_CYCLES boundary.
                        r_hb_cnt    <= HB_LD;
                        r_heartbeat <= 1'b1;
                    end else begin
                        r_hb_cnt <= r_hb_cnt - DLY_W'(1);
                    end
                end
                S_DONE:  ;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.dut_rst_no   = r_dut_rst_n;
    assign bus.load_req_o   = r_load_req;
    assign bus.vcd_on_o     = r_vcd_on;
    assign bus.vcd_seg_o    = r_vcd_seg;
    assign bus.heartbeat_o  = r_heartbeat;
    assign bus.cycle_cnt_o  = r_cycle_cnt;
    assign bus.done_o       = r_done;
    assign bus.pass_o       = r_pass;
    assign bus.fail_o       = r_fail;
    assign bus.timeout_o    = r_timeout;
    assign bus.exit_value_o = r_exit_value;
endmodule

// File: tb/tb_tb_sim_sequencer.sv
// Directed bench for tb_sim_sequencer: reset hold, boot/load handshake, exit,
// timeout, VCD triggering, heartbeat and async reset mid-sequence.
module tb_tb_sim_sequencer;
    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk_i = ~clk_i;

    tb_sim_sequencer_if #(.CNT_W(32)) bus ();

    tb_sim_sequencer #(
        .RST_HOLD_CYCLES (4),
        .BOOT_DLY_CYCLES (3),
        .HEARTBEAT_CYCLES(4),
        .CNT_W           (32)
    ) dut (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        tick();
    endtask

    // Start pulse, then wait through 4 hold + 3 boot-delay cycles (8 edges total).
    task automatic start_seq();
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        repeat (7) tick();
    endtask

    initial begin
        bus.start_i      = 1'b0;
        bus.boot_mode_i  = 2'd0;
        bus.load_done_i  = 1'b0;
        bus.max_cycles_i = 32'd0;
        bus.exit_valid_i = 1'b0;
        bus.exit_value_i = 32'd0;
        bus.vcd_mode_i   = 2'd0;
        bus.vcd_trig_i   = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_dut_rst", bus.dut_rst_no, 0);
        chk("rst_load_req", bus.load_req_o, 0);
        chk("rst_vcd_on", bus.vcd_on_o, 0);
        chk("rst_vcd_seg", bus.vcd_seg_o, 0);
        chk("rst_cnt", bus.cycle_cnt_o, 0);
        chk("rst_flags", {bus.done_o, bus.pass_o, bus.fail_o, bus.timeout_o, bus.heartbeat_o}, 0);
        chk("rst_exit_val", bus.exit_value_o, 0);
        rst_ni = 1'b1;
        tick();

        // Test 1: JTAG boot, unconditional VCD, unlimited, exit 0 at cycle 20
        bus.vcd_mode_i = 2'd1;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t1_hold_low", bus.dut_rst_no, 0);
            tick();
        end
        chk("t1_rst_release", bus.dut_rst_no, 1);
        tick();
        tick();
        chk("t1_boot_vcd_off", bus.vcd_on_o, 0);
        chk("t1_boot_cnt", bus.cycle_cnt_o, 0);
        tick();
        chk("t1_run_vcd_on", bus.vcd_on_o, 1);
        chk("t1_run_seg", bus.vcd_seg_o, 1);
        chk("t1_run_cnt0", bus.cycle_cnt_o, 0);
        chk("t1_run_hb0", bus.heartbeat_o, 0);
        for (int n = 1; n <= 20; n++) begin
            tick();
            chk("t1_cnt", bus.cycle_cnt_o, 64'(n));
            chk("t1_hb", bus.heartbeat_o, ((n % 4) == 0) ? 64'd1 : 64'd0);
        end
        bus.exit_valid_i = 1'b1;
        bus.exit_value_i = 32'd0;
        tick();
        bus.exit_valid_i = 1'b0;
        bus.exit_value_i = 32'h55;
        chk("t1_done", bus.done_o, 1);
        chk("t1_pass", bus.pass_o, 1);
        chk("t1_fail", bus.fail_o, 0);
        chk("t1_timeout", bus.timeout_o, 0);
        chk("t1_exit_val", bus.exit_value_o, 0);
        chk("t1_cnt_frozen", bus.cycle_cnt_o, 21);
        chk("t1_vcd_off_done", bus.vcd_on_o, 0);
        chk("t1_seg_done", bus.vcd_seg_o, 1);
        bus.exit_valid_i = 1'b1;
        repeat (3) tick();
        bus.exit_valid_i = 1'b0;
        chk("t1_cnt_hold", bus.cycle_cnt_o, 21);
        chk("t1_pass_sticky", bus.pass_o, 1);
        chk("t1_exit_val_hold", bus.exit_value_o, 0);

        // Test 2: force-load boot, triggered VCD, timeout at 10
        do_reset();
        bus.boot_mode_i  = 2'd2;
        bus.vcd_mode_i   = 2'd2;
        bus.vcd_trig_i   = 1'b0;
        bus.max_cycles_i = 32'd10;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        repeat (6) tick();
        chk("t2_no_req_yet", bus.load_req_o, 0);
        tick();
        chk("t2_req_high", bus.load_req_o, 1);
        bus.boot_mode_i = 2'd0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_req_hold", bus.load_req_o, 1);
            chk("t2_load_cnt", bus.cycle_cnt_o, 0);
        end
        bus.load_done_i = 1'b1;
        tick();
        bus.load_done_i = 1'b0;
        chk("t2_req_drop", bus.load_req_o, 0);
        chk("t2_run_vcd0", bus.vcd_on_o, 0);
        bus.vcd_trig_i = 1'b1;
        tick();
        chk("t2_trig1", bus.vcd_on_o, 1);
        chk("t2_run_cnt1", bus.cycle_cnt_o, 1);
        bus.vcd_trig_i = 1'b0;
        tick();
        chk("t2_trig0", bus.vcd_on_o, 0);
        bus.vcd_trig_i = 1'b1;
        tick();
        chk("t2_trig1b", bus.vcd_on_o, 1);
        chk("t2_seg2", bus.vcd_seg_o, 2);
        tick();
        chk("t2_hb4", bus.heartbeat_o, 1);
        chk("t2_cnt4", bus.cycle_cnt_o, 4);
        repeat (5) tick();
        chk("t2_cnt9", bus.cycle_cnt_o, 9);
        chk("t2_not_done", bus.done_o, 0);
        tick();
        chk("t2_done", bus.done_o, 1);
        chk("t2_timeout", bus.timeout_o, 1);
        chk("t2_fail", bus.fail_o, 1);
        chk("t2_pass", bus.pass_o, 0);
        chk("t2_cnt10", bus.cycle_cnt_o, 10);
        chk("t2_vcd_forced_off", bus.vcd_on_o, 0);
        tick();
        chk("t2_seg_final", bus.vcd_seg_o, 2);
        chk("t2_vcd_off_hold", bus.vcd_on_o, 0);
        bus.vcd_trig_i = 1'b0;

        // Test 3: exit ignored outside RUN; exit coinciding with timeout wins
        do_reset();
        bus.boot_mode_i  = 2'd0;
        bus.vcd_mode_i   = 2'd0;
        bus.max_cycles_i = 32'd10;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        bus.exit_valid_i = 1'b1;
        bus.exit_value_i = 32'd7;
        tick();
        bus.exit_valid_i = 1'b0;
        repeat (6) tick();
        chk("t3_early_exit_ignored", bus.done_o, 0);
        chk("t3_exit_val_clear", bus.exit_value_o, 0);
        repeat (9) tick();
        chk("t3_cnt9", bus.cycle_cnt_o, 9);
        bus.exit_valid_i = 1'b1;
        bus.exit_value_i = 32'd3;
        tick();
        bus.exit_valid_i = 1'b0;
        chk("t3_done", bus.done_o, 1);
        chk("t3_fail", bus.fail_o, 1);
        chk("t3_pass", bus.pass_o, 0);
        chk("t3_no_timeout", bus.timeout_o, 0);
        chk("t3_exit_val", bus.exit_value_o, 3);
        chk("t3_seg_off_mode", bus.vcd_seg_o, 0);

        // Test 4: async reset during LOAD, then a fresh sequence
        do_reset();
        bus.boot_mode_i  = 2'd2;
        bus.max_cycles_i = 32'd0;
        start_seq();
        chk("t4_in_load", bus.load_req_o, 1);
        chk("t4_dut_out_rst", bus.dut_rst_no, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("t4_async_dut_rst", bus.dut_rst_no, 0);
        chk("t4_async_req", bus.load_req_o, 0);
        chk("t4_async_flags", {bus.done_o, bus.fail_o, bus.timeout_o}, 0);
        tick();
        rst_ni = 1'b1;
        tick();
        bus.boot_mode_i = 2'd0;
        bus.vcd_mode_i  = 2'd1;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        chk("t4_rehold", bus.dut_rst_no, 0);
        repeat (4) tick();
        chk("t4_rerelease", bus.dut_rst_no, 1);
        repeat (3) tick();
        chk("t4_rerun_vcd", bus.vcd_on_o, 1);
        chk("t4_rerun_req", bus.load_req_o, 0);
        tick();
        chk("t4_rerun_cnt", bus.cycle_cnt_o, 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
